// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// This package holds the FSM encodings, counter width and register-address width.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MD_BUSY  = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_RSVD     = 2'b11
  } state_e;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// The master modport is the pipeline; the slave modport is hazard_ctrl itself.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  reg_addr_t          Rs1AddrIdIn;
  reg_addr_t          Rs2AddrIdIn;
  logic               Rs1ReadEnIdIn;
  logic               Rs2ReadEnIdIn;
  reg_addr_t          RdAddrId2ExIn;
  logic               RdWriteEnableId2ExIn;
  logic               MemReadId2ExIn;
  logic               BranchTakenExIn;
  logic               MulDivValidExIn;
  logic               MulDivDoneIn;
  logic               MemBusyIn;
  logic               CntClearIn;

  logic               StallPcOut;
  logic               StallIf2IdOut;
  logic               StallId2ExOut;
  logic               StallEx2MemOut;
  logic               StallMem2WbOut;
  logic               BubbleId2ExOut;
  logic               BubbleEx2MemOut;
  logic               FlushIf2IdOut;
  logic               MulDivStartOut;
  logic [CNT_W-1:0]   StallCycleCntOut;
  logic [1:0]         StateOut;

  modport master (
    output Rs1AddrIdIn, Rs2AddrIdIn, Rs1ReadEnIdIn, Rs2ReadEnIdIn,
    output RdAddrId2ExIn, RdWriteEnableId2ExIn, MemReadId2ExIn,
    output BranchTakenExIn, MulDivValidExIn, MulDivDoneIn, MemBusyIn, CntClearIn,
    input  StallPcOut, StallIf2IdOut, StallId2ExOut, StallEx2MemOut, StallMem2WbOut,
    input  BubbleId2ExOut, BubbleEx2MemOut, FlushIf2IdOut, MulDivStartOut,
    input  StallCycleCntOut, StateOut
  );

  modport slave (
    input  Rs1AddrIdIn, Rs2AddrIdIn, Rs1ReadEnIdIn, Rs2ReadEnIdIn,
    input  RdAddrId2ExIn, RdWriteEnableId2ExIn, MemReadId2ExIn,
    input  BranchTakenExIn, MulDivValidExIn, MulDivDoneIn, MemBusyIn, CntClearIn,
    output StallPcOut, StallIf2IdOut, StallId2ExOut, StallEx2MemOut, StallMem2WbOut,
    output BubbleId2ExOut, BubbleEx2MemOut, FlushIf2IdOut, MulDivStartOut,
    output StallCycleCntOut, StateOut
  );

endinterface

// File: rtl/hazard_ctrl_load_use_det.sv
// Load-use comparator: flags an ID source register produced by a load now in EX.
// x0 is never a producer, so a load targeting x0 can never raise a hazard.
module load_use_det
  import hazard_ctrl_pkg::*;
(
  input  reg_addr_t i_rs1_addr,
  input  reg_addr_t i_rs2_addr,
  input  logic      i_rs1_en,
  input  logic      i_rs2_en,
  input  reg_addr_t i_rd_addr,
  input  logic      i_rd_we,
  input  logic      i_mem_read,
  output logic      o_lu
);

  reg_addr_t  w_src_addr [2];
  logic [1:0] w_src_en;
  logic [1:0] w_src_hit;

  assign w_src_addr[0] = i_rs1_addr;
  assign w_src_addr[1] = i_rs2_addr;
  assign w_src_en      = {i_rs2_en, i_rs1_en};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign w_src_hit[gi] = w_src_en[gi] & (w_src_addr[gi] == i_rd_addr);
    end
  endgenerate

  assign o_lu = i_mem_read & i_rd_we & (i_rd_addr != '0) & (|w_src_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze/mul-div/redirect/load-use priority logic,
// the RUN/MD_BUSY/MEM_WAIT sequencer and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  // Reset value of the stall counter; non-zero only to reach the saturation path quickly.
  parameter logic [CNT_W-1:0] CNT_RST_VAL = '0
)(
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hif
);

  state_e           r_state;
  state_e           w_state_next;
  state_e           w_eff_state;
  logic             r_saved_md;
  logic             w_saved_md_next;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lu;
  logic w_md_pend;
  logic w_stall_pc;
  logic w_stall_if2id;
  logic w_stall_id2ex;
  logic w_stall_ex2mem;
  logic w_stall_mem2wb;
  logic w_bubble_id2ex;
  logic w_bubble_ex2mem;
  logic w_flush_if2id;
  logic w_md_start;

  load_use_det u_lu (
    .i_rs1_addr (hif.Rs1AddrIdIn),
    .i_rs2_addr (hif.Rs2AddrIdIn),
    .i_rs1_en   (hif.Rs1ReadEnIdIn),
    .i_rs2_en   (hif.Rs2ReadEnIdIn),
    .i_rd_addr  (hif.RdAddrId2ExIn),
    .i_rd_we    (hif.RdWriteEnableId2ExIn),
    .i_mem_read (hif.MemReadId2ExIn),
    .o_lu       (w_lu)
  );

  // While frozen the pipe behaves as the state it was frozen from, so the
  // first unfrozen cycle already sees the right mul/div and start behaviour.
  always_comb begin
    w_eff_state = ST_RUN;
    case (r_state)
      ST_MD_BUSY:  w_eff_state = ST_MD_BUSY;
      ST_MEM_WAIT: w_eff_state = r_saved_md ? ST_MD_BUSY : ST_RUN;
      default:     w_eff_state = ST_RUN;
    endcase
  end

  assign w_md_pend  = ((w_eff_state == ST_MD_BUSY) | hif.MulDivValidExIn) & ~hif.MulDivDoneIn;
  assign w_md_start = (w_eff_state == ST_RUN) & hif.MulDivValidExIn & ~hif.MemBusyIn;

  always_comb begin
    w_stall_pc      = 1'b0;
    w_stall_if2id   = 1'b0;
    w_stall_id2ex   = 1'b0;
    w_stall_ex2mem  = 1'b0;
    w_stall_mem2wb  = 1'b0;
    w_bubble_id2ex  = 1'b0;
    w_bubble_ex2mem = 1'b0;
    w_flush_if2id   = 1'b0;
    if (hif.MemBusyIn) begin
      w_stall_pc     = 1'b1;
      w_stall_if2id  = 1'b1;
      w_stall_id2ex  = 1'b1;
      w_stall_ex2mem = 1'b1;
      w_stall_mem2wb = 1'b1;
    end else if (w_md_pend) begin
      w_stall_pc      = 1'b1;
      w_stall_if2id   = 1'b1;
      w_stall_id2ex   = 1'b1;
      w_bubble_ex2mem = 1'b1;
    end else if (hif.BranchTakenExIn) begin
      w_flush_if2id  = 1'b1;
      w_bubble_id2ex = 1'b1;
    end else if (w_lu) begin
      w_stall_pc     = 1'b1;
      w_stall_if2id  = 1'b1;
      w_bubble_id2ex = 1'b1;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_saved_md_next = r_saved_md;
    if (r_state == ST_RSVD) begin
      w_state_next = ST_RUN;
    end else if (hif.MemBusyIn) begin
      w_state_next = ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT) begin
        w_saved_md_next = (r_state == ST_MD_BUSY);
      end
    end else if (w_eff_state == ST_MD_BUSY) begin
      w_state_next = hif.MulDivDoneIn ? ST_RUN : ST_MD_BUSY;
    end else begin
      w_state_next = (hif.MulDivValidExIn & ~hif.MulDivDoneIn) ? ST_MD_BUSY : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_saved_md <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_saved_md <= w_saved_md_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= CNT_RST_VAL;
    end else if (hif.CntClearIn) begin
      r_stall_cnt <= '0;
    end else if (w_stall_pc) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign hif.StallPcOut       = w_stall_pc;
  assign hif.StallIf2IdOut    = w_stall_if2id;
  assign hif.StallId2ExOut    = w_stall_id2ex;
  assign hif.StallEx2MemOut   = w_stall_ex2mem;
  assign hif.StallMem2WbOut   = w_stall_mem2wb;
  assign hif.BubbleId2ExOut   = w_bubble_id2ex;
  assign hif.BubbleEx2MemOut  = w_bubble_ex2mem;
  assign hif.FlushIf2IdOut    = w_flush_if2id;
  assign hif.MulDivStartOut   = w_md_start;
  assign hif.StallCycleCntOut = r_stall_cnt;
  assign hif.StateOut         = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a behavioural model
// that tracks only "mul/div outstanding", "frozen last cycle" and the counter.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();
  hazard_ctrl_if hif_sat();

  hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hif(hif));
  hazard_ctrl #(.CNT_RST_VAL(32'hFFFF_FFFE)) dut_sat (.clk(clk), .rst_n(rst_n), .hif(hif_sat));

  int checks = 0;
  int errors = 0;

  bit          m_md_out;
  bit          m_frozen;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input bit en1, input bit en2,
                        input logic [4:0] rd, input bit we, input bit mr, input bit br,
                        input bit mdv, input bit mdd, input bit busy, input bit clr);
    hif.Rs1AddrIdIn = rs1;  hif.Rs2AddrIdIn = rs2;
    hif.Rs1ReadEnIdIn = en1; hif.Rs2ReadEnIdIn = en2;
    hif.RdAddrId2ExIn = rd; hif.RdWriteEnableId2ExIn = we; hif.MemReadId2ExIn = mr;
    hif.BranchTakenExIn = br; hif.MulDivValidExIn = mdv; hif.MulDivDoneIn = mdd;
    hif.MemBusyIn = busy; hif.CntClearIn = clr;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_md_out = 0;
    m_frozen = 0;
    m_cnt    = 32'd0;
  endtask

  // Expected {StallPc,StallIf2Id,StallId2Ex,StallEx2Mem,StallMem2Wb,BubbleId2Ex,BubbleEx2Mem,Flush,Start}
  function automatic logic [8:0] spec_ctl(input bit busy, input bit pend, input bit br,
                                          input bit lu, input bit start);
    if (busy)      return 9'b11111_00_0_0;
    else if (pend) return {7'b11100_01, 1'b0, start};
    else if (br)   return {7'b00000_10, 1'b1, start};
    else if (lu)   return {7'b11000_10, 1'b0, start};
    else           return {8'b0, start};
  endfunction

  // Compare one cycle at the falling edge, then advance the model across the rising edge.
  task automatic step(input string tag);
    bit lu, pend, start, busy;
    logic [8:0] exp_v, obs_v;
    logic [1:0] exp_st;
    @(negedge clk);
    busy = hif.MemBusyIn;
    lu = hif.MemReadId2ExIn && hif.RdWriteEnableId2ExIn && (hif.RdAddrId2ExIn != 0) &&
         ((hif.Rs1ReadEnIdIn && hif.Rs1AddrIdIn == hif.RdAddrId2ExIn) ||
          (hif.Rs2ReadEnIdIn && hif.Rs2AddrIdIn == hif.RdAddrId2ExIn));
    pend  = (m_md_out || hif.MulDivValidExIn) && !hif.MulDivDoneIn;
    start = !m_md_out && hif.MulDivValidExIn && !busy;
    exp_v = spec_ctl(busy, pend, hif.BranchTakenExIn, lu, start);
    obs_v = {hif.StallPcOut, hif.StallIf2IdOut, hif.StallId2ExOut, hif.StallEx2MemOut,
             hif.StallMem2WbOut, hif.BubbleId2ExOut, hif.BubbleEx2MemOut,
             hif.FlushIf2IdOut, hif.MulDivStartOut};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s_ctl observed=%b expected=%b", tag, obs_v, exp_v);
    end
    exp_st = m_frozen ? 2'b10 : (m_md_out ? 2'b01 : 2'b00);
    checks++;
    assert (hif.StateOut === exp_st) else begin
      errors++;
      $error("FAIL %s_state observed=%b expected=%b", tag, hif.StateOut, exp_st);
    end
    checks++;
    assert (hif.StallCycleCntOut === m_cnt) else begin
      errors++;
      $error("FAIL %s_cnt observed=%0h expected=%0h", tag, hif.StallCycleCntOut, m_cnt);
    end
    if (hif.CntClearIn) m_cnt = 32'd0;
    else if (exp_v[8] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (!busy) begin
      if (m_md_out) begin
        if (hif.MulDivDoneIn) m_md_out = 0;
      end else if (hif.MulDivValidExIn && !hif.MulDivDoneIn) begin
        m_md_out = 1;
      end
    end
    m_frozen = busy;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] md_states [4];

  initial begin
    md_states[0] = 2'b00; md_states[1] = 2'b01; md_states[2] = 2'b01; md_states[3] = 2'b01;
    idle();
    hif_sat.Rs1AddrIdIn = 0; hif_sat.Rs2AddrIdIn = 0; hif_sat.Rs1ReadEnIdIn = 0;
    hif_sat.Rs2ReadEnIdIn = 0; hif_sat.RdAddrId2ExIn = 0; hif_sat.RdWriteEnableId2ExIn = 0;
    hif_sat.MemReadId2ExIn = 0; hif_sat.BranchTakenExIn = 0; hif_sat.MulDivValidExIn = 0;
    hif_sat.MulDivDoneIn = 0; hif_sat.MemBusyIn = 0; hif_sat.CntClearIn = 0;
    model_reset();

    // Reset state
    #12;
    chk("rst_state", hif.StateOut, 2'b00);
    chk("rst_cnt", hif.StallCycleCntOut, 32'd0);
    chk("rst_stallpc", hif.StallPcOut, 1'b0);
    chk("rst_sat_preload", hif_sat.StallCycleCntOut, 32'hFFFF_FFFE);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Load x5 in EX, ID reads x5 -> one stall cycle
    set_in(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, 0, 0);
    #1;
    chk("lu_stallpc", hif.StallPcOut, 1'b1);
    chk("lu_stallif", hif.StallIf2IdOut, 1'b1);
    chk("lu_bubble", hif.BubbleId2ExOut, 1'b1);
    step("lu_x5");
    idle();
    #1;
    chk("lu_released", hif.StallPcOut, 1'b0);
    chk("lu_cnt", hif.StallCycleCntOut, 32'd1);
    step("lu_after");

    // Load to x0 never stalls
    set_in(5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, 0, 0);
    #1;
    chk("x0_stallpc", hif.StallPcOut, 1'b0);
    step("x0");

    // Branch beats a simultaneous load-use
    set_in(5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 1, 0, 0, 0, 0);
    #1;
    chk("br_flush", hif.FlushIf2IdOut, 1'b1);
    chk("br_bubble", hif.BubbleId2ExOut, 1'b1);
    chk("br_stallpc", hif.StallPcOut, 1'b0);
    step("br_lu");

    // Mul/div held four cycles, done on the fourth
    for (int c = 0; c < 4; c++) begin
      set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, (c == 3), 0, 0);
      #1;
      chk($sformatf("md_c%0d_state", c + 1), hif.StateOut, md_states[c]);
      chk($sformatf("md_c%0d_start", c + 1), hif.MulDivStartOut, (c == 0));
      chk($sformatf("md_c%0d_stallpc", c + 1), hif.StallPcOut, (c < 3));
      chk($sformatf("md_c%0d_bubex", c + 1), hif.BubbleEx2MemOut, (c < 3));
      step("md");
    end
    idle();
    chk("md_end_state", hif.StateOut, 2'b00);

    // Memory freeze for two cycles inside MD_BUSY
    set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0);
    step("mw_start");
    for (int c = 0; c < 2; c++) begin
      set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 1, 0);
      #1;
      chk($sformatf("mw_c%0d_allstall", c), {hif.StallPcOut, hif.StallIf2IdOut, hif.StallId2ExOut,
          hif.StallEx2MemOut, hif.StallMem2WbOut}, 5'b11111);
      chk($sformatf("mw_c%0d_state", c), hif.StateOut, (c == 0) ? 2'b01 : 2'b10);
      step("mw_busy");
    end
    set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("mw_unfreeze_state", hif.StateOut, 2'b10);
    step("mw_unfreeze");
    chk("mw_back_md", hif.StateOut, 2'b01);
    set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, 0);
    step("mw_done");
    idle();

    // Clear wins over a simultaneous increment
    set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1);
    step("clr");
    chk("clr_cnt", hif.StallCycleCntOut, 32'd0);
    idle();
    step("clr_idle");

    // Asynchronous reset in the middle of MD_BUSY
    set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0);
    step("ar_start");
    step("ar_busy");
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_state", hif.StateOut, 2'b00);
    chk("ar_cnt", hif.StallCycleCntOut, 32'd0);
    chk("ar_start_quiet", hif.MulDivStartOut, 1'b0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step("ar_after");

    // Saturation from a preloaded counter
    hif_sat.MemBusyIn = 1'b1;
    @(posedge clk); #1;
    chk("sat_first", hif_sat.StallCycleCntOut, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hif_sat.MemBusyIn = 1'b0;
    chk("sat_hold", hif_sat.StallCycleCntOut, 32'hFFFF_FFFF);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
